if_fetch_unit: RTL and testbench

Instruction-fetch stage sitting directly upstream of the decode stage. Owns the fetch PC and issues word reads to instruction memory over a req/ack handshake. Buffers returned words in a small prefetch queue and presents the head instruction and its PC+4 to decode. Honours the hazard stall (freeze) and branch redirects from the execute stage.

---
 rtl/if_fetch_unit.sv | 191 +++++++++++++++++++
 tb/tb_if_fetch_unit.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_unit.sv
// ---------------------------------------------------------------------------
// if_fetch_unit
//
// Instruction-fetch stage feeding the decode stage. Owns the fetch PC,
// issues single-word reads to instruction memory over a req/ack handshake,
// buffers returned words in a small prefetch queue and presents the head
// instruction (with its address + 4) to decode. Honours the hazard stall
// (freeze) and redirects coming back from the execute stage.
//
// Parameters
//   DEPTH     prefetch queue entries (power of two, >= 2)
//   RESET_PC  first fetch address after reset
//
// Ports
//   clk           in   rising-edge clock
//   rst           in   asynchronous reset, active-low
//   freeze        in   hazard stall: head instruction is not consumed
//   branch_taken  in   redirect request from EXE (flushes the queue)
//   branch_addr   in   redirect target, word aligned
//   imem_req      out  memory read request (held until acknowledged)
//   imem_addr     out  memory read address, stable while imem_req=1
//   imem_ack      in   read complete, imem_rdata valid this cycle
//   imem_rdata    in   read data
//   Instruction   out  head instruction, 0 when inst_valid=0
//   PC            out  head instruction address + 4, 0 when inst_valid=0
//   inst_valid    out  prefetch queue non-empty
// ---------------------------------------------------------------------------
module if_fetch_unit #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        freeze,
    input  logic        branch_taken,
    input  logic [31:0] branch_addr,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] Instruction,
    output logic [31:0] PC,
    output logic        inst_valid
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } fetchState_e;

    fetchState_e       state_q,    state_d;
    logic [31:0]       fetchPc_q,  fetchPc_d;
    logic [31:0]       reqAddr_q,  reqAddr_d;
    logic [CNT_W-1:0]  count_q,    count_d;
    logic [PTR_W-1:0]  headPtr_q,  headPtr_d;
    logic [PTR_W-1:0]  tailPtr_q,  tailPtr_d;

    logic [31:0]       qInstr [DEPTH];
    logic [31:0]       qAddr  [DEPTH];

    logic              push;
    logic              pop;
    logic              hasRoom;

    // Queue head drives decode directly; everything is forced to zero when
    // the queue is empty so decode never sees stale words.
    always_comb begin
        inst_valid  = (count_q != '0);
        Instruction = 32'h0;
        PC          = 32'h0;
        if (inst_valid) begin
            Instruction = qInstr[headPtr_q];
            PC          = qAddr[headPtr_q] + 32'd4;
        end
    end

    assign imem_req  = (state_q != IDLE);
    assign imem_addr = reqAddr_q;

    // A word is only kept when it answers a live (non-dropped) request and
    // no redirect is happening on the same edge. A redirect also blocks the
    // pop, since the head is wrong-path anyway.
    always_comb begin
        push = (state_q == WAIT) && imem_ack && !branch_taken;
        pop  = inst_valid && !freeze && !branch_taken;
    end

    // Occupancy after this edge; the fetch FSM uses it to decide whether
    // another request can be launched without overflowing the queue.
    always_comb begin
        count_d   = count_q + CNT_W'(push) - CNT_W'(pop);
        headPtr_d = headPtr_q + PTR_W'(pop);
        tailPtr_d = tailPtr_q + PTR_W'(push);
        if (branch_taken) begin
            count_d   = '0;
            headPtr_d = '0;
            tailPtr_d = '0;
        end
        hasRoom = (count_d < DEPTH_C);
    end

    // Fetch FSM next state. DROP marks a request that must still complete
    // on the bus (address held) but whose data belongs to the old path.
    always_comb begin
        state_d   = state_q;
        fetchPc_d = fetchPc_q;
        reqAddr_d = reqAddr_q;
        case (state_q)
            IDLE: begin
                if (branch_taken) begin
                    fetchPc_d = branch_addr;
                    reqAddr_d = branch_addr;
                    state_d   = WAIT;
                end else if (hasRoom) begin
                    reqAddr_d = fetchPc_q;
                    state_d   = WAIT;
                end
            end
            WAIT: begin
                if (imem_ack) begin
                    if (branch_taken) begin
                        fetchPc_d = branch_addr;
                        reqAddr_d = branch_addr;
                        state_d   = WAIT;
                    end else begin
                        fetchPc_d = reqAddr_q + 32'd4;
                        if (hasRoom) begin
                            reqAddr_d = reqAddr_q + 32'd4;
                            state_d   = WAIT;
                        end else begin
                            state_d   = IDLE;
                        end
                    end
                end else if (branch_taken) begin
                    fetchPc_d = branch_addr;
                    state_d   = DROP;
                end
            end
            DROP: begin
                if (imem_ack) begin
                    if (branch_taken) begin
                        fetchPc_d = branch_addr;
                        reqAddr_d = branch_addr;
                    end else begin
                        reqAddr_d = fetchPc_q;
                    end
                    state_d = WAIT;
                end else if (branch_taken) begin
                    fetchPc_d = branch_addr;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            fetchPc_q <= RESET_PC;
            reqAddr_q <= 32'h0;
            count_q   <= '0;
            headPtr_q <= '0;
            tailPtr_q <= '0;
        end else begin
            state_q   <= state_d;
            fetchPc_q <= fetchPc_d;
            reqAddr_q <= reqAddr_d;
            count_q   <= count_d;
            headPtr_q <= headPtr_d;
            tailPtr_q <= tailPtr_d;
        end
    end

    // Queue storage needs no reset: entries are only visible through the
    // count, which is reset.
    always_ff @(posedge clk) begin
        if (push) begin
            qInstr[tailPtr_q] <= imem_rdata;
            qAddr[tailPtr_q]  <= reqAddr_q;
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_if_fetch_unit
//
// Directed testbench for if_fetch_unit. A small behavioural memory returns
// memWord(addr) and acknowledges in the same cycle whenever ackGate is set,
// so delayed acks are produced by holding ackGate low. Inputs change and
// outputs are sampled 1ns after each rising edge.
// ---------------------------------------------------------------------------
module tb_if_fetch_unit;

    logic        clk;
    logic        rst;
    logic        freeze;
    logic        branch_taken;
    logic [31:0] branch_addr;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] Instruction;
    logic [31:0] PC;
    logic        inst_valid;

    logic        ackGate;
    int          totalCount;
    int          badCount;

    if_fetch_unit #(
        .DEPTH    (4),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .freeze       (freeze),
        .branch_taken (branch_taken),
        .branch_addr  (branch_addr),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
        .Instruction  (Instruction),
        .PC           (PC),
        .inst_valid   (inst_valid)
    );

    // Memory content is a fixed function of the address so every expected
    // instruction word can be written down directly.
    function automatic logic [31:0] memWord(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    assign imem_rdata = memWord(imem_addr);
    assign imem_ack   = imem_req & ackGate;

    // 10ns clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point: counts the check and reports any mismatch.
    task automatic checkOutput(input string tag, input logic [31:0] obs,
                               input logic [31:0] exp);
        totalCount++;
        if (obs !== exp) begin
            badCount++;
            $display("[TB] FAIL %s: got=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drives all non-reset inputs at once.
    task automatic applyStimulus(input logic frz, input logic br,
                                 input logic [31:0] brAddr, input logic ack);
        freeze       = frz;
        branch_taken = br;
        branch_addr  = brAddr;
        ackGate      = ack;
    endtask

    // Advances one clock and lands 1ns past the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Holds reset over a couple of edges and releases it between edges.
    task automatic doReset();
        rst = 1'b0;
        step();
        step();
        rst = 1'b1;
    endtask

    initial begin
        totalCount = 0;
        badCount   = 0;
        rst        = 1'b0;
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);

        // Reset state
        step();
        step();
        checkOutput("rst_req",   {31'b0, imem_req},   32'h0);
        checkOutput("rst_addr",  imem_addr,           32'h0);
        checkOutput("rst_valid", {31'b0, inst_valid}, 32'h0);
        checkOutput("rst_instr", Instruction,         32'h0);
        checkOutput("rst_pc",    PC,                  32'h0);
        rst = 1'b1;

        // Zero-wait streaming: one fetch and one delivery per cycle
        step();
        checkOutput("zw_addr0",  imem_addr,           32'h0);
        checkOutput("zw_req0",   {31'b0, imem_req},   32'h1);
        checkOutput("zw_valid0", {31'b0, inst_valid}, 32'h0);
        step();
        checkOutput("zw_addr1",  imem_addr,           32'h4);
        checkOutput("zw_instr1", Instruction,         memWord(32'h0));
        checkOutput("zw_pc1",    PC,                  32'h4);
        step();
        checkOutput("zw_addr2",  imem_addr,           32'h8);
        checkOutput("zw_instr2", Instruction,         memWord(32'h4));
        checkOutput("zw_pc2",    PC,                  32'h8);
        step();
        checkOutput("zw_addr3",  imem_addr,           32'hC);
        checkOutput("zw_pc3",    PC,                  32'hC);

        // Freeze held: queue fills to 4 then requests stop
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
        doReset();
        step();
        checkOutput("fz_addr0", imem_addr, 32'h0);
        step();
        step();
        step();
        checkOutput("fz_addr3", imem_addr, 32'hC);
        checkOutput("fz_req3",  {31'b0, imem_req}, 32'h1);
        step();
        checkOutput("fz_req_full",   {31'b0, imem_req},   32'h0);
        checkOutput("fz_valid_full", {31'b0, inst_valid}, 32'h1);
        checkOutput("fz_instr_full", Instruction,         memWord(32'h0));
        checkOutput("fz_pc_full",    PC,                  32'h4);
        step();
        checkOutput("fz_req_hold", {31'b0, imem_req}, 32'h0);
        checkOutput("fz_pc_hold",  PC,                32'h4);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        step();
        checkOutput("fz_rel_req",   {31'b0, imem_req}, 32'h1);
        checkOutput("fz_rel_addr",  imem_addr,         32'h10);
        checkOutput("fz_rel_instr", Instruction,       memWord(32'h4));
        checkOutput("fz_rel_pc",    PC,                32'h8);
        step();
        checkOutput("fz_next_addr", imem_addr, 32'h14);
        checkOutput("fz_next_pc",   PC,        32'hC);

        // Ack delayed 3 cycles: address and request held, a single push
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
        doReset();
        step();
        checkOutput("dl_addr_w1", imem_addr, 32'h0);
        checkOutput("dl_req_w1",  {31'b0, imem_req}, 32'h1);
        step();
        checkOutput("dl_addr_w2", imem_addr, 32'h0);
        step();
        checkOutput("dl_addr_w3",  imem_addr,           32'h0);
        checkOutput("dl_req_w3",   {31'b0, imem_req},   32'h1);
        checkOutput("dl_valid_w3", {31'b0, inst_valid}, 32'h0);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        step();
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
        checkOutput("dl_ack_instr", Instruction, memWord(32'h0));
        checkOutput("dl_ack_pc",    PC,          32'h4);
        checkOutput("dl_ack_addr",  imem_addr,   32'h4);
        step();
        checkOutput("dl_pop_valid", {31'b0, inst_valid}, 32'h0);
        checkOutput("dl_pop_addr",  imem_addr,           32'h4);

        // Redirect while the request for 0x8 is outstanding
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
        doReset();
        step();
        step();
        step();
        checkOutput("br_pre_addr",  imem_addr, 32'h8);
        checkOutput("br_pre_valid", {31'b0, inst_valid}, 32'h1);
        applyStimulus(1'b0, 1'b1, 32'h100, 1'b0);
        step();
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
        checkOutput("br_flush_valid", {31'b0, inst_valid}, 32'h0);
        checkOutput("br_drop_addr",   imem_addr,           32'h8);
        checkOutput("br_drop_req",    {31'b0, imem_req},   32'h1);
        step();
        checkOutput("br_drop_addr2", imem_addr, 32'h8);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        step();
        checkOutput("br_disc_valid", {31'b0, inst_valid}, 32'h0);
        checkOutput("br_tgt_addr",   imem_addr,           32'h100);
        step();
        checkOutput("br_first_instr", Instruction, memWord(32'h100));
        checkOutput("br_first_pc",    PC,          32'h104);
        checkOutput("br_next_addr",   imem_addr,   32'h104);

        // Redirect on the same edge as the ack for 0x8, with freeze high
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
        doReset();
        step();
        step();
        step();
        checkOutput("ba_pre_addr", imem_addr, 32'h8);
        applyStimulus(1'b1, 1'b1, 32'h100, 1'b1);
        step();
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
        checkOutput("ba_valid", {31'b0, inst_valid}, 32'h0);
        checkOutput("ba_addr",  imem_addr,           32'h100);
        checkOutput("ba_req",   {31'b0, imem_req},   32'h1);
        checkOutput("ba_instr", Instruction,         32'h0);

        // Asynchronous reset in the middle of a wait at 0x20
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        doReset();
        for (int i = 0; i < 9; i++) begin
            step();
        end
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
        checkOutput("ar_pre_addr", imem_addr, 32'h20);
        checkOutput("ar_pre_pc",   PC,        32'h20);
        #2;
        rst = 1'b0;
        #1;
        checkOutput("ar_req",   {31'b0, imem_req},   32'h0);
        checkOutput("ar_valid", {31'b0, inst_valid}, 32'h0);
        checkOutput("ar_pc",    PC,                  32'h0);
        checkOutput("ar_addr",  imem_addr,           32'h0);
        step();
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        rst = 1'b1;
        step();
        checkOutput("ar_restart_addr", imem_addr,         32'h0);
        checkOutput("ar_restart_req",  {31'b0, imem_req}, 32'h1);

        // Redirect to the top word: next fetch address wraps to 0
        applyStimulus(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1);
        step();
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        checkOutput("wr_addr",  imem_addr,           32'hFFFF_FFFC);
        checkOutput("wr_valid", {31'b0, inst_valid}, 32'h0);
        step();
        checkOutput("wr_wrap_addr", imem_addr,           32'h0);
        checkOutput("wr_instr",     Instruction,         memWord(32'hFFFF_FFFC));
        checkOutput("wr_wrap_pc",   PC,                  32'h0);
        checkOutput("wr_valid2",    {31'b0, inst_valid}, 32'h1);

        $display("test done: total=%0d bad=%0d", totalCount, badCount);
        $finish;
    end

endmodule
